mag_approx_pipe: RTL
====================

Name: mag_approx_pipe

Overview:
Streaming alpha-max-plus-beta-min magnitude estimator for 2-D vectors (X, Y), parametrised in width and signedness.
- Run-time selectable coefficient mode.
- Valid/ready handshake on both sides.
- 3-stage stallable pipeline.
- Optional output saturation with a flag.
- Sits between sample sources (ADC/CORDIC front-ends, pin inputs) and downstream thresholding/display logic.

Parameters:
W, 8, input component width in bits (W >= 4)
SIGNED, 0, 1 = inputs are two's complement (absolute value taken); 0 = unsigned
SAT, 0, 1 = clamp result to 2^W-1 and raise out_sat; 0 = full W+1-bit result

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
in_x  input  W  X component
in_y  input  W  Y component
in_mode  input  2  coefficient mode, travels with the sample
in_valid  input  1  input sample valid
in_ready  output  1  block can accept a sample this cycle
out_mag  output  W+1  magnitude estimate
out_sat  output  1  result was clamped (SAT=1 only, else 0)
out_valid  output  1  out_mag/out_sat valid
out_ready  input  1  downstream accepts output

Behaviour:
- Reset: rst_n is asynchronous, active-low; clk is the clock. All stage valids are 0, out_mag=0, out_sat=0, out_valid=0. in_ready=1 after reset releases.
- Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational). Input transfer = in_valid && in_ready. Output transfer = out_valid && out_ready.
- When advance=0, all stage registers and valids hold. When advance=1, every stage shifts by one and stage-1 valid takes in_valid.
- Bubbles are not collapsed.
- Latency: 3 cycles from input transfer to out_valid when unstalled. Throughput is 1 sample/cycle. Sample order is preserved and no sample is dropped or duplicated under any out_ready pattern.
- S1: register |x|, |y| (W bits unsigned) and mode.
  - SIGNED=0: passthrough.
  - SIGNED=1: negate when MSB set; -2^(W-1) maps to 2^(W-1) (fits in W unsigned bits).
- S2: mx = max(|x|,|y|), mn = min(|x|,|y|). For x==y, mx = mn = that value.
- S3: compute r in W+2 bits. Each shift is a logical right shift, truncated independently before summing:
  - mode 0: r = mx + (mn>>1)
  - mode 1: r = mx + (mn>>2)
  - mode 2: r = mx + (mn>>2) + (mn>>3)
  - mode 3: r = mx - (mx>>4) + (mn>>1) - (mn>>5)
- Width: r is always < 2^(W+1), so SAT=0 gives out_mag = r[W:0] and out_sat = 0.
- SAT=1: if r > 2^W-1 then out_mag = 2^W-1 and out_sat = 1; else out_mag = r and out_sat = 0.
- out_mag/out_sat update only on advance with valid S3 data. Between transfers they hold their last values.
- Reset mid-stream: all in-flight samples are discarded immediately. Outputs return to reset values asynchronously.
- Mode changes between consecutive samples take effect per sample, with no flush or extra latency.

Test Plan:
- W=8, SIGNED=0, SAT=0, mode 0, x=200, y=100, out_ready=1 -> out_mag=250 exactly 3 cycles after transfer. Then x=255, y=255 -> 382, out_sat=0.
- Same x=255, y=255 with SAT=1 -> out_mag=255, out_sat=1. Then x=100, y=40 -> 120, out_sat=0.
- Modes on x=100, y=40: mode 1 -> 110, mode 2 -> 115. Mode 3 on x=160, y=64 -> 180. Back-to-back samples with alternating modes each give the correct per-sample result.
- SIGNED=1, mode 0: x=0x80 (-128), y=64 -> 160. x=-10, y=-30 -> 35. x=y=-7 -> 10.
- Stream 10 samples with in_valid=1 and out_ready low for 5 cycles mid-stream -> in_ready falls in the same cycle that out_valid&&!out_ready holds. All 10 results emerge in order, none lost or duplicated, and out_mag stays stable while stalled.
- Assert rst_n low with 3 samples in flight -> out_valid=0 and out_mag=0 immediately. After release no stale sample appears and in_ready=1.

Source files
------------

// File: rtl/mag_approx_pipe_if.sv
// Streaming port bundle for mag_approx_pipe: input sample channel
// (x, y, mode with valid/ready) and output magnitude channel
// (mag, sat with valid/ready). The block itself connects via the
// slave modport; a sample source / sink connects via master.
interface mag_approx_pipe_if #(
  parameter int W = 8
);

  logic [W-1:0] in_x;
  logic [W-1:0] in_y;
  logic [1:0]   in_mode;
  logic         in_valid;
  logic         in_ready;
  logic [W:0]   out_mag;
  logic         out_sat;
  logic         out_valid;
  logic         out_ready;

  modport slave (
    input  in_x,
    input  in_y,
    input  in_mode,
    input  in_valid,
    output in_ready,
    output out_mag,
    output out_sat,
    output out_valid,
    input  out_ready
  );

  modport master (
    output in_x,
    output in_y,
    output in_mode,
    output in_valid,
    input  in_ready,
    input  out_mag,
    input  out_sat,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mag_approx_pipe.sv
// Alpha-max-plus-beta-min magnitude estimator for 2-D vectors.
// Three register stages (abs -> max/min -> weighted sum) share one
// global stall: the whole pipe advances whenever the output register
// is empty or being drained. Bubbles travel through like samples.
// Coefficient mode rides along with each sample, so mode changes
// need no flush.
module mag_approx_pipe #(
  parameter int W      = 8,
  parameter int SIGNED = 0,
  parameter int SAT    = 0
) (
  input logic             clk,
  input logic             rst_n,
  mag_approx_pipe_if.slave bus
);

  // Absolute value in W unsigned bits. For the most negative input the
  // two's-complement negation yields the same bit pattern, which read
  // as unsigned is exactly 2^(W-1), so no extra bit is needed.
  function automatic logic [W-1:0] abs_val(input logic [W-1:0] v);
    logic [W-1:0] res;
    if ((SIGNED != 0) && v[W-1]) begin
      res = (~v) + {{(W-1){1'b0}}, 1'b1};
    end else begin
      res = v;
    end
    return res;
  endfunction

  // Weighted sum in W+2 bits; the two guard bits keep mode 3's
  // intermediate subtraction and every mode's sum from wrapping.
  function automatic logic [W+1:0] weigh(input logic [W-1:0] mx,
                                         input logic [W-1:0] mn,
                                         input logic [1:0]   mode);
    logic [W+1:0] mx_e;
    logic [W+1:0] mn_e;
    logic [W+1:0] res;
    mx_e = {2'b00, mx};
    mn_e = {2'b00, mn};
    case (mode)
      2'd0:    res = mx_e + (mn_e >> 3'd1);
      2'd1:    res = mx_e + (mn_e >> 3'd2);
      2'd2:    res = mx_e + (mn_e >> 3'd2) + (mn_e >> 3'd3);
      2'd3:    res = mx_e - (mx_e >> 3'd4) + (mn_e >> 3'd1) - (mn_e >> 3'd5);
      default: res = mx_e;
    endcase
    return res;
  endfunction

  localparam logic [W+1:0] SAT_LIM_W2 = {2'b00, {W{1'b1}}};
  localparam logic [W:0]   SAT_LIM_W1 = {1'b0, {W{1'b1}}};

  logic           advance_s;

  logic           v1_r;
  logic [W-1:0]   ax1_r;
  logic [W-1:0]   ay1_r;
  logic [1:0]     m1_r;

  logic [W-1:0]   mx_s;
  logic [W-1:0]   mn_s;

  logic           v2_r;
  logic [W-1:0]   mx2_r;
  logic [W-1:0]   mn2_r;
  logic [1:0]     m2_r;

  logic [W+1:0]   r_s;
  logic [W:0]     mag_s;
  logic           sat_s;

  logic           out_valid_r;
  logic [W:0]     out_mag_r;
  logic           out_sat_r;

  // Single global stall: move everything when the output slot frees up.
  always_comb begin
    advance_s = (!out_valid_r) || bus.out_ready;
  end

  assign bus.in_ready  = advance_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_mag   = out_mag_r;
  assign bus.out_sat   = out_sat_r;

  // Stage 1: capture absolute components and the sample's mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r  <= 1'b0;
      ax1_r <= {W{1'b0}};
      ay1_r <= {W{1'b0}};
      m1_r  <= 2'd0;
    end else if (advance_s) begin
      v1_r <= bus.in_valid;
      if (bus.in_valid) begin
        ax1_r <= abs_val(bus.in_x);
        ay1_r <= abs_val(bus.in_y);
        m1_r  <= bus.in_mode;
      end
    end
  end

  // Order the two magnitudes; equal inputs give mx == mn.
  always_comb begin
    mx_s = ax1_r;
    mn_s = ay1_r;
    if (ax1_r >= ay1_r) begin
      mx_s = ax1_r;
      mn_s = ay1_r;
    end else begin
      mx_s = ay1_r;
      mn_s = ax1_r;
    end
  end

  // Stage 2: register the max/min pair with its mode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r  <= 1'b0;
      mx2_r <= {W{1'b0}};
      mn2_r <= {W{1'b0}};
      m2_r  <= 2'd0;
    end else if (advance_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        mx2_r <= mx_s;
        mn2_r <= mn_s;
        m2_r  <= m1_r;
      end
    end
  end

  // Weighted sum and optional clamp to the W-bit range.
  always_comb begin
    r_s   = weigh(mx2_r, mn2_r, m2_r);
    mag_s = r_s[W:0];
    sat_s = 1'b0;
    if ((SAT != 0) && (r_s > SAT_LIM_W2)) begin
      mag_s = SAT_LIM_W1;
      sat_s = 1'b1;
    end else begin
      mag_s = r_s[W:0];
      sat_s = 1'b0;
    end
  end

  // Stage 3: output register; payload only changes when a real sample lands.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r <= 1'b0;
      out_mag_r   <= {(W+1){1'b0}};
      out_sat_r   <= 1'b0;
    end else if (advance_s) begin
      out_valid_r <= v2_r;
      if (v2_r) begin
        out_mag_r <= mag_s;
        out_sat_r <= sat_s;
      end
    end
  end

endmodule
